// File: rtl/ps2_mouse_ctrl_pkg.sv
// Shared definitions for the PS/2 mouse controller.
// Contents: controller state enum, PS/2 command and response bytes,
// bit positions inside the 25-bit ps2_mouse bus, and the helper that
// turns a raw 3-byte movement packet into the bus payload.
package ps2_mouse_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    ST_SEND_RST,
    ST_ACK_RST,
    ST_WAIT_AA,
    ST_WAIT_ID,
    ST_SEND_EN,
    ST_ACK_EN,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_FAIL
  } state_t;

  // Host -> mouse commands
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  // Mouse -> host responses
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_DEV_ID   = 8'h00;

  // ps2_mouse field positions
  localparam int PM_SYNC   = 3;
  localparam int PM_XSIGN  = 4;
  localparam int PM_YSIGN  = 5;
  localparam int PM_XOVF   = 6;
  localparam int PM_YOVF   = 7;
  localparam int PM_DX_LSB = 8;
  localparam int PM_DY_LSB = 16;
  localparam int PM_TOGGLE = 24;

  // Build ps2_mouse[23:0] from status/dX/dY. An overflowed axis carries
  // no usable delta, so its delta and sign are forced to zero while the
  // overflow flag itself is passed through.
  function automatic logic [23:0] build_packet(input logic [7:0] status,
                                               input logic [7:0] dx,
                                               input logic [7:0] dy);
    logic [7:0] s;
    logic [7:0] x;
    logic [7:0] y;
    s = status;
    x = dx;
    y = dy;
    if (status[PM_XOVF]) begin
      s[PM_XSIGN] = 1'b0;
      x           = 8'h00;
    end
    if (status[PM_YOVF]) begin
      s[PM_YSIGN] = 1'b0;
      y           = 8'h00;
    end
    return {y, x, s};
  endfunction

endpackage

// File: rtl/ps2_mouse_ctrl_if.sv
// Byte-level link between the mouse controller and the PS/2 serial
// transceiver.
//   rx_valid/rx_data : one-cycle strobe with a received byte
//   tx_data/tx_valid : command byte, tx_valid held until tx_ready
//   tx_ready         : transceiver accepts when tx_valid & tx_ready
// master = controller side, slave = transceiver side.
interface ps2_mouse_ctrl_if;
  import ps2_mouse_ctrl_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  rx_valid, rx_data, tx_ready,
    output tx_data, tx_valid
  );

  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  tx_data, tx_valid
  );
endinterface

// File: rtl/ps2_mouse_ctrl_timer.sv
// Loadable up-counter with terminal-count compare.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : synchronous clear to zero (wins over en_i)
//   en_i         : count enable
//   tc_o         : high while enabled and the count equals LIMIT-1
module ps2_mouse_ctrl_timer #(
  parameter int LIMIT = 56000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == CW'(LIMIT - 1));

  // Hold at terminal count; the owner leaves the timed state on tc_o.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse controller: resets the mouse (FF -> FA, AA, 00), enables
// streaming (F4 -> FA), then frames 3-byte movement packets onto the
// 25-bit ps2_mouse bus used by the Kempston mouse port logic.
//   clk_sys, reset : system clock, asynchronous active-high reset
//   reinit         : one-cycle pulse, restart initialisation
//   bus            : byte link to the PS/2 transceiver (master side)
//   ps2_mouse      : [2:0] M/R/L, [3] sync, [4] X sign, [5] Y sign,
//                    [7:6] Y/X overflow, [15:8] dX, [23:16] dY,
//                    [24] toggles once per completed packet
//   ready          : mouse is streaming
//   init_fail      : initialisation retries exhausted
module ps2_mouse_ctrl
  import ps2_mouse_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 28000000,
  parameter int GAP_CYCLES     = 56000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                reinit,
  ps2_mouse_ctrl_if.master    bus,
  output logic [24:0]         ps2_mouse,
  output logic                ready,
  output logic                init_fail
);

  localparam int RW = $clog2(MAX_RETRIES + 1);

  state_t        state_q;
  logic [RW-1:0] retry_q;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;
  logic [24:0]   mouse_q;
  logic          ready_q;
  logic          fail_q;
  logic [7:0]    status_q;
  logic [7:0]    dx_q;

  logic in_wait, in_pkt;
  logic init_tc, gap_tc;
  logic init_tmo, gap_tmo;
  logic retry_evt, retry_last;
  logic tx_hs;

  // Response that moves each waiting state forward
  function automatic logic [7:0] expected_resp(input state_t s);
    case (s)
      ST_ACK_RST, ST_ACK_EN: return RSP_ACK;
      ST_WAIT_AA:            return RSP_BAT_OK;
      default:               return RSP_DEV_ID;
    endcase
  endfunction

  assign in_wait = (state_q == ST_ACK_RST) || (state_q == ST_WAIT_AA) ||
                   (state_q == ST_WAIT_ID) || (state_q == ST_ACK_EN);
  assign in_pkt  = (state_q == ST_B1) || (state_q == ST_B2);
  assign tx_hs   = tx_valid_q && bus.tx_ready;

  // Timers restart on every received byte and outside their states, so
  // each waiting state gets the full window from its entry.
  ps2_mouse_ctrl_timer #(.LIMIT(TIMEOUT_CYCLES)) u_init_timer (
    .clk_i (clk_sys),
    .rst_i (reset),
    .clr_i (!in_wait || bus.rx_valid || reinit),
    .en_i  (in_wait),
    .tc_o  (init_tc)
  );

  ps2_mouse_ctrl_timer #(.LIMIT(GAP_CYCLES)) u_gap_timer (
    .clk_i (clk_sys),
    .rst_i (reset),
    .clr_i (!in_pkt || bus.rx_valid || reinit),
    .en_i  (in_pkt),
    .tc_o  (gap_tc)
  );

  assign init_tmo = init_tc && !bus.rx_valid;
  assign gap_tmo  = gap_tc && !bus.rx_valid;

  // Any wrong byte or a timeout in a waiting state costs one attempt.
  assign retry_evt  = in_wait &&
                      ((bus.rx_valid && (bus.rx_data != expected_resp(state_q))) ||
                       init_tmo);
  assign retry_last = (32'(retry_q) + 32'd1) >= 32'(MAX_RETRIES);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SEND_RST;
      retry_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      mouse_q    <= '0;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else if (reinit) begin
      state_q    <= ST_SEND_RST;
      retry_q    <= '0;
      tx_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else if (retry_evt) begin
      retry_q <= retry_q + 1'b1;
      if (retry_last) begin
        state_q <= ST_FAIL;
        fail_q  <= 1'b1;
        ready_q <= 1'b0;
      end else begin
        state_q <= ST_SEND_RST;
      end
    end else begin
      case (state_q)
        ST_SEND_RST: begin
          if (tx_hs) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_ACK_RST;
          end else begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= CMD_RESET;
          end
        end
        ST_ACK_RST: if (bus.rx_valid) state_q <= ST_WAIT_AA;
        ST_WAIT_AA: if (bus.rx_valid) state_q <= ST_WAIT_ID;
        ST_WAIT_ID: if (bus.rx_valid) state_q <= ST_SEND_EN;
        ST_SEND_EN: begin
          if (tx_hs) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_ACK_EN;
          end else begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= CMD_ENABLE;
          end
        end
        ST_ACK_EN: begin
          if (bus.rx_valid) begin
            state_q <= ST_B0;
            ready_q <= 1'b1;
            retry_q <= '0;
          end
        end
        // Bytes without the sync bit cannot start a packet.
        ST_B0: if (bus.rx_valid && bus.rx_data[PM_SYNC]) state_q <= ST_B1;
        ST_B1: begin
          if (bus.rx_valid) begin
            // AA then 00 is a freshly plugged mouse announcing itself.
            if (status_q == RSP_BAT_OK && bus.rx_data == RSP_DEV_ID) begin
              state_q <= ST_SEND_EN;
              ready_q <= 1'b0;
            end else begin
              state_q <= ST_B2;
            end
          end else if (gap_tmo) begin
            state_q <= ST_B0;
          end
        end
        ST_B2: begin
          if (bus.rx_valid) begin
            mouse_q <= {~mouse_q[PM_TOGGLE], build_packet(status_q, dx_q, bus.rx_data)};
            state_q <= ST_B0;
          end else if (gap_tmo) begin
            state_q <= ST_B0;
          end
        end
        ST_FAIL: state_q <= ST_FAIL;
        default: state_q <= ST_SEND_RST;
      endcase
    end
  end

  // Packet byte holding registers; only read after being written.
  always_ff @(posedge clk_sys) begin
    if (!reinit && bus.rx_valid) begin
      if (state_q == ST_B0 && bus.rx_data[PM_SYNC]) status_q <= bus.rx_data;
      if (state_q == ST_B1) dx_q <= bus.rx_data;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign ps2_mouse    = mouse_q;
  assign ready        = ready_q;
  assign init_fail    = fail_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
module tb_ps2_mouse_ctrl;
  import ps2_mouse_ctrl_pkg::*;

  localparam int TMO  = 200;
  localparam int GAP  = 40;
  localparam int RETR = 3;
  localparam int WAIT_LIM = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reinit = 1'b0;
  logic [24:0] ps2_mouse;
  logic        ready, init_fail;

  ps2_mouse_ctrl_if ifc ();

  ps2_mouse_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .GAP_CYCLES     (GAP),
    .MAX_RETRIES    (RETR)
  ) dut (
    .clk_sys   (clk),
    .reset     (rst),
    .reinit    (reinit),
    .bus       (ifc.master),
    .ps2_mouse (ps2_mouse),
    .ready     (ready),
    .init_fail (init_fail)
  );

  always #5 clk = ~clk;

  logic [7:0] tx_q[$];
  always @(posedge clk) begin
    if (ifc.tx_valid && ifc.tx_ready) tx_q.push_back(ifc.tx_data);
  end

  int checks = 0;
  int errors = 0;
  logic        exp_tog = 1'b0;
  logic [23:0] exp_pkt = 24'h0;

  typedef struct packed {
    logic [2:0]  n;
    logic [31:0] bytes;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is consumed.
  task automatic send_byte(input logic [7:0] b);
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    @(negedge clk);
    ifc.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input logic [7:0] exp, input string name);
    int start;
    int n;
    start = tx_q.size();
    n = 0;
    while (tx_q.size() == start && n < WAIT_LIM) begin
      @(negedge clk);
      n++;
    end
    check({name, "_seen"}, 32'(tx_q.size() > start), 32'd1);
    if (tx_q.size() > start) begin
      check(name, 32'(tx_q[start]), 32'(exp));
      check({name, "_drop"}, 32'(ifc.tx_valid), 32'd0);
    end
  endtask

  task automatic full_init(input string tag);
    wait_tx(CMD_RESET, {tag, "_ff"});
    send_byte(RSP_ACK);
    send_byte(RSP_BAT_OK);
    send_byte(RSP_DEV_ID);
    wait_tx(CMD_ENABLE, {tag, "_f4"});
    send_byte(RSP_ACK);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_nofail"}, 32'(init_fail), 32'd0);
  endtask

  task automatic check_mouse(input string name);
    check(name, 32'(ps2_mouse), 32'({exp_tog, exp_pkt}));
  endtask

  initial begin
    int start, n, cnt;
    logic all_ff;

    vecs[0] = '{3'd3, 32'h0905FB00, 24'hFB0509};
    vecs[1] = '{3'd4, 32'h02081020, 24'h201008};
    vecs[2] = '{3'd3, 32'h487F0300, 24'h030048};
    vecs[3] = '{3'd3, 32'h3880FF00, 24'hFF8038};
    vecs[4] = '{3'd3, 32'hF9123400, 24'h0000C9};
    vecs[5] = '{3'd3, 32'h0F01FF00, 24'hFF010F};

    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    ifc.tx_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mouse", 32'(ps2_mouse), 32'd0);
    check("rst_txv", 32'(ifc.tx_valid), 32'd0);
    check("rst_txd", 32'(ifc.tx_data), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fail", 32'(init_fail), 32'd0);
    rst = 1'b0;

    // Power-up initialisation
    full_init("init");

    // Table of stream packets
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(vecs[i].n)) send_byte(vecs[i].bytes[31 - 8*k -: 8]);
      end
      exp_tog = ~exp_tog;
      exp_pkt = vecs[i].exp;
      check($sformatf("vec%0d", i), 32'(ps2_mouse), 32'({exp_tog, exp_pkt}));
    end
    check("left_btn", 32'(ps2_mouse[0]), 32'd1);

    // Gap timeout drops a partial packet
    send_byte(8'h08);
    send_byte(8'h10);
    repeat (GAP + 10) @(negedge clk);
    check_mouse("gap_hold");
    send_byte(8'h08);
    send_byte(8'h01);
    send_byte(8'h02);
    exp_tog = ~exp_tog;
    exp_pkt = 24'h020108;
    check_mouse("gap_after");

    // Hot-plug: AA then 00 re-enables streaming
    send_byte(RSP_BAT_OK);
    send_byte(RSP_DEV_ID);
    check("hp_ready0", 32'(ready), 32'd0);
    wait_tx(CMD_ENABLE, "hp_f4");
    send_byte(RSP_ACK);
    check("hp_ready1", 32'(ready), 32'd1);
    check_mouse("hp_hold");

    // Silent mouse: retries exhausted
    start = tx_q.size();
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    check("reinit_ready", 32'(ready), 32'd0);
    check_mouse("reinit_hold");
    n = 0;
    while (!init_fail && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("fail_set", 32'(init_fail), 32'd1);
    repeat (TMO + 50) @(negedge clk);
    cnt = tx_q.size() - start;
    all_ff = 1'b1;
    for (int j = start; j < tx_q.size(); j++) if (tx_q[j] != CMD_RESET) all_ff = 1'b0;
    check("fail_ff_count", 32'(cnt), 32'd3);
    check("fail_all_ff", 32'(all_ff), 32'd1);
    check("fail_ready", 32'(ready), 32'd0);
    check("fail_txv", 32'(ifc.tx_valid), 32'd0);
    check_mouse("fail_hold");

    // Recover with reinit, exercising BAT failure and resend retries
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    check("reinit_fail_clr", 32'(init_fail), 32'd0);
    wait_tx(CMD_RESET, "re_ff1");
    send_byte(RSP_ACK);
    send_byte(RSP_BAT_FAIL);
    wait_tx(CMD_RESET, "re_ff2");
    send_byte(RSP_ACK);
    send_byte(RSP_BAT_OK);
    send_byte(RSP_DEV_ID);
    wait_tx(CMD_ENABLE, "re_f4a");
    send_byte(RSP_RESEND);
    full_init("re");

    send_byte(8'h0A);
    send_byte(8'h11);
    send_byte(8'h22);
    exp_tog = ~exp_tog;
    exp_pkt = 24'h22110A;
    check_mouse("re_pkt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
